activation_unit: RTL and testbench
==================================

Name: activation_unit

Overview:
- Multi-channel, mode-selectable activation stage that follows the accumulator / requantisation path of the CNN datapath.
- Applies one of four activations to CHANNELS signed lanes per beat.
- Rescales each lane by a rounded arithmetic right shift and saturates to OUTPUT_WIDTH.
- Valid/ready handshake, 2-stage elastic pipeline, saturating count of clipped lanes.

Parameters:
CHANNELS, 4, lanes per beat
INPUT_WIDTH, 20, signed width of each input lane
OUTPUT_WIDTH, 16, signed width of each output lane (must be <= INPUT_WIDTH)
OUT_SHIFT, 4, requantisation right shift (0 = none)
LEAKY_SHIFT, 3, negative slope for leaky mode = 2^-LEAKY_SHIFT
SAT_CNT_WIDTH, 16, width of saturation counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  CHANNELS*INPUT_WIDTH  signed lanes, lane 0 in LSBs
in_mode  in  2  activation mode, sampled with the beat
in_last  in  1  end-of-tile marker, carried unchanged with the beat
cfg_clamp  in  INPUT_WIDTH  unsigned upper bound for clamp mode, sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  CHANNELS*OUTPUT_WIDTH  signed results, lane 0 in LSBs
out_last  out  1  delayed in_last
sat_clr  in  1  synchronous clear of sat_count
sat_count  out  SAT_CNT_WIDTH  saturating count of clipped lanes

Behaviour:
- Reset (rst_n low at a clk edge): s1_valid, out_valid, out_data, out_last and sat_count go to 0. All in-flight beats are dropped. in_ready is 0 while rst_n is low.
- Stage 1 (activation), INPUT_WIDTH-wide, per lane x:
  - mode 0 BYPASS: x.
  - mode 1 RELU: x<0 ? 0 : x.
  - mode 2 LEAKY: x<0 ? x>>>LEAKY_SHIFT (floor) : x.
  - mode 3 CLAMP: x<0 ? 0 : min(x, cfg_clamp).
  - In simulation, a lane containing X/Z is forced to 0.
- Stage 2 (requantise), per lane:
  - If OUT_SHIFT>0: y = (a + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, computed in INPUT_WIDTH+1 bits so there is no overflow. If OUT_SHIFT=0: y = a.
  - Saturate y to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - Lanes that clip raise a per-lane sat flag.
- Latency: exactly 2 cycles from the accepting edge to out_valid, absent backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - Each stage advances when its successor is empty or transferring. in_ready = !s1_valid | s1_adv.
  - out_valid, out_data and out_last stay stable while out_valid & !out_ready.
  - No beat is lost, duplicated or reordered. Capacity is 2 beats.
- Mode and clamp are per-beat. Changing in_mode between beats affects only later beats.
- sat_count:
  - On the edge that loads the stage-2 register, adds popcount(sat flags) and saturates at all-ones.
  - sat_clr forces 0 and wins over a same-cycle increment; that cycle's count is discarded.
- Reset mid-operation: takes effect at the next edge regardless of handshake state.

Decomposition:
- Package act_pkg holds:
  - enum act_mode_e {ACT_BYPASS=0, ACT_RELU=1, ACT_LEAKY=2, ACT_CLAMP=3};
  - the popcount function.
- Sub-module act_lane: one channel's stage-1 and stage-2 combinational datapath plus its sat flag. Instantiated CHANNELS times in a generate loop.
- Top level owns the valid/ready control, the pipeline registers and sat_count.

Test Plan (default parameters):
- RELU: lanes {100,-100,0,524287}, out_ready=1 -> out {6,0,0,32767} exactly 2 cycles later; sat_count=1.
- LEAKY: lanes {-160,-1,-8,32} -> stage1 {-20,-1,-1,32}; out {-1,0,0,2}; no saturation.
- CLAMP with cfg_clamp=96: lanes {200,-5,50,96} -> out {6,0,3,6}. BYPASS with lane -524288 -> -32768, no sat increment.
- Backpressure: continuous in_valid with incrementing data, out_ready=0 for 5 cycles -> exactly 2 beats accepted, then in_ready=0. After release, outputs appear in order without gaps/duplicates; out_last follows its beat.
- sat_count: sat_clr asserted in the same cycle a 4-lane saturating beat loads -> sat_count=0. Preloaded to 65534, then a 4-lane saturating beat -> 65535 and holds.
- rst_n pulsed low with 2 beats in flight -> out_valid=0, out_data=0, sat_count=0 next edge. No stale beat emerges after rst_n rises.

Source files
------------

// File: rtl/act_pkg.sv
// Shared definitions for the activation stage.
//   act_mode_e : per-beat activation selector carried on in_mode
//   popcount   : number of set bits in a 32-bit vector; used to count the
//                clipped lanes of one beat
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLAMP  = 2'd3
  } act_mode_e;

  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/act_lane.sv
// One channel of the activation stage (combinational only).
//   i_x      : raw signed lane from the accumulator path
//   i_mode   : activation selector for the beat being accepted
//   i_clamp  : unsigned upper bound used in clamp mode
//   o_act    : activated value, registered by the top into stage 1
//   i_act_p1 : stage-1 registered activated value
//   o_y      : rounded, shifted and saturated result for stage 2
//   o_sat    : high when o_y was clipped
module act_lane
  import act_pkg::*;
#(
  parameter int INPUT_WIDTH  = 20,
  parameter int OUTPUT_WIDTH = 16,
  parameter int OUT_SHIFT    = 4,
  parameter int LEAKY_SHIFT  = 3
) (
  input  logic signed [INPUT_WIDTH-1:0]  i_x,
  input  act_mode_e                      i_mode,
  input  logic        [INPUT_WIDTH-1:0]  i_clamp,
  output logic signed [INPUT_WIDTH-1:0]  o_act,
  input  logic signed [INPUT_WIDTH-1:0]  i_act_p1,
  output logic signed [OUTPUT_WIDTH-1:0] o_y,
  output logic                           o_sat
);

  localparam int IW = INPUT_WIDTH;
  localparam int OW = OUTPUT_WIDTH;

  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [IW:0] RND     = (IW+1)'((2 ** OUT_SHIFT) / 2);
  localparam logic signed [IW:0] SAT_MAX = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW:0] SAT_MIN = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  // One guard bit keeps the rounding add from overflowing.
  function automatic logic signed [IW:0] round_shift(input logic signed [IW-1:0] a);
    logic signed [IW:0] ext;
    ext = {a[IW-1], a};
    return (ext + RND) >>> OUT_SHIFT;
  endfunction

  function automatic logic is_clipped(input logic signed [IW:0] y);
    return (y > SAT_MAX) || (y < SAT_MIN);
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [IW:0] y);
    if (y > SAT_MAX) return SAT_MAX[OW-1:0];
    if (y < SAT_MIN) return SAT_MIN[OW-1:0];
    return y[OW-1:0];
  endfunction

  logic signed [IW:0] w_shifted;

  // Stage 1 boundary: activation on the incoming lane
  always_comb begin
    o_act = i_x;
    case (i_mode)
      ACT_RELU:  if (i_x[IW-1]) o_act = '0;
      ACT_LEAKY: if (i_x[IW-1]) o_act = i_x >>> LEAKY_SHIFT;
      ACT_CLAMP: begin
        // x is non-negative here, so x > clamp implies clamp fits a positive signed lane.
        if (i_x[IW-1])                   o_act = '0;
        else if ($unsigned(i_x) > i_clamp) o_act = $signed(i_clamp);
      end
      default:   o_act = i_x;
    endcase
`ifndef SYNTHESIS
    if ($isunknown(i_x)) o_act = '0;
`endif
  end

  // Stage 2 boundary: requantise the registered activation
  always_comb begin
    w_shifted = round_shift(i_act_p1);
    o_y       = saturate(w_shifted);
    o_sat     = is_clipped(w_shifted);
  end

endmodule

// File: rtl/activation_unit.sv
// Multi-channel activation stage with a 2-deep elastic pipeline.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_data              : CHANNELS signed lanes, lane 0 in LSBs
//   in_mode, cfg_clamp   : activation selector and clamp bound, per beat
//   in_last / out_last   : end-of-tile marker travelling with its beat
//   out_valid/out_ready  : output handshake
//   out_data             : CHANNELS saturated lanes, lane 0 in LSBs
//   sat_clr, sat_count   : clear and saturating count of clipped lanes
module activation_unit
  import act_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int INPUT_WIDTH   = 20,
  parameter int OUTPUT_WIDTH  = 16,
  parameter int OUT_SHIFT     = 4,
  parameter int LEAKY_SHIFT   = 3,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*INPUT_WIDTH-1:0]  in_data,
  input  logic [1:0]                       in_mode,
  input  logic                             in_last,
  input  logic [INPUT_WIDTH-1:0]           cfg_clamp,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNELS*OUTPUT_WIDTH-1:0] out_data,
  output logic                             out_last,
  input  logic                             sat_clr,
  output logic [SAT_CNT_WIDTH-1:0]         sat_count
);

  localparam int IW = INPUT_WIDTH;
  localparam int OW = OUTPUT_WIDTH;

  logic                          r_vld_p1, r_vld_p2;
  logic                          r_last_p1, r_last_p2;
  logic signed [IW-1:0]          r_act_p1 [CHANNELS];
  logic [CHANNELS*OW-1:0]        r_data_p2;
  logic [SAT_CNT_WIDTH-1:0]      r_sat_cnt;

  logic signed [IW-1:0]          w_act [CHANNELS];
  logic [CHANNELS*OW-1:0]        w_y;
  logic [CHANNELS-1:0]           w_sat;
  logic                          w_s2_adv, w_s1_adv, w_s1_open, w_in_fire;
  logic [SAT_CNT_WIDTH:0]        w_cnt_sum;
  logic [SAT_CNT_WIDTH-1:0]      w_cnt_next;

  assign w_s2_adv  = !r_vld_p2 || out_ready;
  assign w_s1_adv  = r_vld_p1 && w_s2_adv;
  assign w_s1_open = !r_vld_p1 || w_s1_adv;
  assign in_ready  = rst_n && w_s1_open;
  assign w_in_fire = in_valid && in_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic signed [OW-1:0] w_lane_y;
    act_lane #(
      .INPUT_WIDTH  (INPUT_WIDTH),
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .OUT_SHIFT    (OUT_SHIFT),
      .LEAKY_SHIFT  (LEAKY_SHIFT)
    ) u_lane (
      .i_x      ($signed(in_data[g*IW +: IW])),
      .i_mode   (act_mode_e'(in_mode)),
      .i_clamp  (cfg_clamp),
      .o_act    (w_act[g]),
      .i_act_p1 (r_act_p1[g]),
      .o_y      (w_lane_y),
      .o_sat    (w_sat[g])
    );
    assign w_y[g*OW +: OW] = w_lane_y;
  end

  assign w_cnt_sum  = {1'b0, r_sat_cnt} + (SAT_CNT_WIDTH+1)'(popcount(32'(w_sat)));
  assign w_cnt_next = w_cnt_sum[SAT_CNT_WIDTH] ? '1 : w_cnt_sum[SAT_CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_s1_open) r_vld_p1 <= in_valid;
      if (w_s2_adv)  r_vld_p2 <= r_vld_p1;
    end
  end

  // Stage 1 boundary: activated lanes
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_act_p1  <= w_act;
      r_last_p1 <= in_last;
    end
  end

  // Stage 2 boundary: requantised lanes presented on out_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_p2 <= '0;
      r_last_p2 <= 1'b0;
    end else if (w_s1_adv) begin
      r_data_p2 <= w_y;
      r_last_p2 <= r_last_p1;
    end
  end

  // Clear wins over an increment landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_sat_cnt <= '0;
    else if (sat_clr)  r_sat_cnt <= '0;
    else if (w_s1_adv) r_sat_cnt <= w_cnt_next;
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_last  = r_last_p2;
  assign sat_count = r_sat_cnt;

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit at default parameters.
module tb_activation_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_data;
  logic [1:0]  in_mode;
  logic        in_last;
  logic [19:0] cfg_clamp;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        sat_clr;
  logic [15:0] sat_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  activation_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .cfg_clamp (cfg_clamp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] pin(input int a, input int b, input int c, input int d);
    return {20'(d), 20'(c), 20'(b), 20'(a)};
  endfunction

  function automatic logic [63:0] pout(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Drive one beat with out_ready high and check it 2 cycles later.
  task automatic run_beat(input string tag, input logic [79:0] din, input logic [1:0] mode,
                          input logic [19:0] clamp, input logic last,
                          input logic [63:0] exp_out, input logic [15:0] exp_cnt);
    @(negedge clk);
    in_valid = 1'b1; in_data = din; in_mode = mode; cfg_clamp = clamp; in_last = last;
    #1 chk({tag, "_rdy"}, 80'(in_ready), 80'(1));
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; in_mode = ~mode; cfg_clamp = '0; in_last = ~last;
    chk({tag, "_early"}, 80'(out_valid), 80'(0));
    @(negedge clk);
    chk({tag, "_vld"},  80'(out_valid), 80'(1));
    chk({tag, "_data"}, 80'(out_data),  80'(exp_out));
    chk({tag, "_last"}, 80'(out_last),  80'(last));
    chk({tag, "_cnt"},  80'(sat_count), 80'(exp_cnt));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_last = 1'b0;
    cfg_clamp = '0; out_ready = 1'b1; sat_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vld",  80'(out_valid), 80'(0));
    chk("rst_data", 80'(out_data),  80'(0));
    chk("rst_last", 80'(out_last),  80'(0));
    chk("rst_cnt",  80'(sat_count), 80'(0));
    chk("rst_rdy",  80'(in_ready),  80'(0));
    rst_n = 1'b1;

    // Activation modes
    run_beat("relu",   pin(100, -100, 0, 524287),  2'd1, 20'd0,  1'b1, pout(6, 0, 0, 32767),      16'd1);
    run_beat("leaky",  pin(-160, -1, -8, 32),       2'd2, 20'd0,  1'b0, pout(-1, 0, 0, 2),         16'd1);
    run_beat("clamp",  pin(200, -5, 50, 96),        2'd3, 20'd96, 1'b1, pout(6, 0, 3, 6),          16'd1);
    run_beat("bypass", pin(-524288, 0, 16, -16),    2'd0, 20'd0,  1'b0, pout(-32768, 0, 1, -1),    16'd1);

    // Backpressure: stall output, only 2 beats fit
    @(negedge clk);
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = pin(16*k, 16*k, 16*k, 16*k); in_mode = 2'd0; in_last = k[0];
      #1 if (in_ready) k++;
      @(negedge clk);
    end
    in_data = pin(16*k, 16*k, 16*k, 16*k); in_last = k[0];
    #1;
    chk("bp_accepted", 80'(k), 80'(2));
    chk("bp_rdy",      80'(in_ready), 80'(0));
    chk("bp_hold_v",   80'(out_valid), 80'(1));
    chk("bp_hold_d",   80'(out_data), 80'(pout(0, 0, 0, 0)));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (k < 8); in_data = pin(16*k, 16*k, 16*k, 16*k); in_last = k[0];
      #1;
      chk("bp_vld",  80'(out_valid), 80'(1));
      chk("bp_data", 80'(out_data),  80'(pout(i, i, i, i)));
      chk("bp_last", 80'(out_last),  80'(i % 2));
      if (in_valid && in_ready) k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_total", 80'(k), 80'(8));
    chk("bp_nodup", 80'(out_valid), 80'(0));

    // sat_clr wins over a same-cycle 4-lane increment
    @(negedge clk);
    in_valid = 1'b1; in_data = pin(524287, 524287, 524287, 524287); in_mode = 2'd0; in_last = 1'b0;
    #1 chk("clr_pre", 80'(sat_count), 80'(1));
    @(negedge clk);
    in_valid = 1'b0; sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("clr_data", 80'(out_data),  80'(pout(32767, 32767, 32767, 32767)));
    chk("clr_cnt",  80'(sat_count), 80'(0));

    // Preload counter to 65534 with a full-rate stream, then saturate
    for (int i = 0; i < 16383; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = pin(524287, 524287, 524287, 524287);
    end
    @(negedge clk);
    in_data = pin(524287, 524287, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_cnt", 80'(sat_count), 80'(65534));
    run_beat("satmax",  pin(524287, 524287, 524287, 524287), 2'd0, 20'd0, 1'b1,
             pout(32767, 32767, 32767, 32767), 16'd65535);
    run_beat("sathold", pin(-524288, 524287, -524288, 524287), 2'd0, 20'd0, 1'b0,
             pout(-32768, 32767, -32768, 32767), 16'd65535);

    // Reset with 2 beats in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = pin(524287, 32, 48, 64); in_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ro_pre_v",   80'(out_valid), 80'(1));
    chk("ro_pre_rdy", 80'(in_ready),  80'(0));
    rst_n = 1'b0;
    @(negedge clk);
    chk("ro_vld",  80'(out_valid), 80'(0));
    chk("ro_data", 80'(out_data),  80'(0));
    chk("ro_last", 80'(out_last),  80'(0));
    chk("ro_cnt",  80'(sat_count), 80'(0));
    chk("ro_rdy",  80'(in_ready),  80'(0));
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ro_stale", 80'(out_valid), 80'(0));
    end
    run_beat("post_rst", pin(16, 32, 48, 64), 2'd1, 20'd0, 1'b1, pout(1, 2, 3, 4), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
